rx_agc: RTL and testbench

Receive-side automatic gain control for the DSP modem. Sits directly after the channel model, ahead of the matched filter and slicer. It measures the mean magnitude of the received sample stream over fixed symbol windows and adjusts a multiplicative gain so the output level converges to a programmed target, undoing the channel's selectable gain. A two-state loop uses a fast step during acquisition and a slow step once locked.

---
 rtl/dsp_modem_pkg.sv | 35 +++
 rtl/agc_level_detector.sv | 47 ++++
 rtl/rx_agc.sv | 116 +++++++++++
 tb/tb_rx_agc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_modem_pkg.sv
// Shared fixed-point constants, AGC state encoding and sample helpers for the DSP modem.
package dsp_modem_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int GAIN_FRAC = 14;
  localparam int GAIN_W    = 18;
  localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 18'sh20000;

  typedef enum logic {
    AGC_ACQUIRE = 1'b0,
    AGC_TRACK   = 1'b1
  } agc_state_e;

  // Overflow whenever the bits above the sample MSB are not a pure sign extension.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [PROD_W-1:0] v);
    logic [PROD_W-SAMPLE_W-1:0] upper;
    upper = v[PROD_W-2:SAMPLE_W-1];
    if (!v[PROD_W-1] && (|upper)) return SAT_MAX;
    if (v[PROD_W-1] && !(&upper)) return SAT_MIN;
    return v[SAMPLE_W-1:0];
  endfunction

  // The most negative sample folds onto the most positive magnitude.
  function automatic logic [SAMPLE_W-2:0] abs_mag(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = -s;
    if (s == SAT_MIN) return SAT_MAX[SAMPLE_W-2:0];
    if (s[SAMPLE_W-1]) return neg[SAMPLE_W-2:0];
    return s[SAMPLE_W-2:0];
  endfunction

endpackage

// File: rtl/agc_level_detector.sv
// Mean-magnitude detector: accumulates |sig| on each symbol strobe over 2^WIN_LOG2 symbols.
module agc_level_detector
  import dsp_modem_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sym_clk_ena,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] sig,
  output logic        [SAMPLE_W-2:0] avg,
  output logic                       win_done
);

  localparam int ACC_W = SAMPLE_W - 1 + WIN_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [WIN_LOG2-1:0] sym_cnt;
  logic [SAMPLE_W-2:0] mag;

  assign mag      = abs_mag(sig);
  assign acc_sum  = acc + ACC_W'(mag);
  assign avg      = acc_sum[ACC_W-1:WIN_LOG2];
  // Combinational so the gain update lands on the closing symbol edge itself.
  assign win_done = sym_clk_ena && !clear && (sym_cnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      sym_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      sym_cnt <= '0;
    end else if (sym_clk_ena) begin
      if (win_done) begin
        acc     <= '0;
        sym_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        sym_cnt <= sym_cnt + WIN_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/rx_agc.sv
// Receive AGC: multiplicative gain, windowed level detector and a two-state acquire/track loop.
module rx_agc
  import dsp_modem_pkg::*;
#(
  parameter int WIN_LOG2   = 4,
  parameter int TARGET     = 32768,
  parameter int GAIN_INIT  = 16384,
  parameter int GAIN_MIN   = 1024,
  parameter int GAIN_MAX   = 262143,
  parameter int MU_ACQ     = 2,
  parameter int MU_TRK     = 6,
  parameter int LOCK_TOL   = 2048,
  parameter int UNLOCK_TOL = 8192,
  parameter int LOCK_CNT   = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sam_clk_ena,
  input  logic                       sym_clk_ena,
  input  logic                       agc_hold,
  input  logic signed [SAMPLE_W-1:0] sig_in,
  output logic signed [SAMPLE_W-1:0] sig_out,
  output logic        [GAIN_W-1:0]   gain_out,
  output logic                       locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic signed [SAMPLE_W:0] TARGET_S = (SAMPLE_W+1)'(TARGET);
  localparam logic signed [GAIN_W+1:0] GMIN_S   = (GAIN_W+2)'(GAIN_MIN);
  localparam logic signed [GAIN_W+1:0] GMAX_S   = (GAIN_W+2)'(GAIN_MAX);

  agc_state_e                state, state_nxt;
  logic [GAIN_W-1:0]         gain, gain_nxt, gain_clamp;
  logic [CNT_W-1:0]          lock_cnt, lock_cnt_nxt;
  logic signed [PROD_W-1:0]  prod;
  logic [SAMPLE_W-2:0]       avg;
  logic                      win_done;
  logic signed [SAMPLE_W:0]  err, step;
  logic [SAMPLE_W:0]         err_mag;
  logic signed [GAIN_W+1:0]  gain_sum;
  logic                      in_tol, out_tol;

  assign prod = PROD_W'(sig_in) * PROD_W'($signed({1'b0, gain}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sig_out <= '0;
    else if (sam_clk_ena) sig_out <= sat_sample(prod >>> GAIN_FRAC);
  end

  agc_level_detector #(.WIN_LOG2(WIN_LOG2)) u_level (
    .clk         (clk),
    .reset_n     (reset_n),
    .sym_clk_ena (sym_clk_ena),
    .clear       (agc_hold),
    .sig         (sig_out),
    .avg         (avg),
    .win_done    (win_done)
  );

  assign err      = TARGET_S - $signed({2'b00, avg});
  assign err_mag  = err[SAMPLE_W] ? (SAMPLE_W+1)'(-err) : (SAMPLE_W+1)'(err);
  assign in_tol   = err_mag <= (SAMPLE_W+1)'(LOCK_TOL);
  assign out_tol  = err_mag >  (SAMPLE_W+1)'(UNLOCK_TOL);
  // Loop bandwidth follows the state held before this window's decision.
  assign step     = (state == AGC_TRACK) ? (err >>> MU_TRK) : (err >>> MU_ACQ);
  assign gain_sum = $signed({2'b00, gain}) + $signed({step[SAMPLE_W], step});

  always_comb begin
    gain_clamp = gain_sum[GAIN_W-1:0];
    if (gain_sum < GMIN_S) gain_clamp = GAIN_W'(GAIN_MIN);
    else if (gain_sum > GMAX_S) gain_clamp = GAIN_W'(GAIN_MAX);
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    gain_nxt     = gain;
    if (win_done) begin
      gain_nxt = gain_clamp;
      case (state)
        AGC_ACQUIRE: begin
          if (!in_tol) begin
            lock_cnt_nxt = '0;
          end else if (lock_cnt == CNT_W'(LOCK_CNT - 1)) begin
            state_nxt    = AGC_TRACK;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
          end
        end
        AGC_TRACK: begin
          if (out_tol) begin
            state_nxt    = AGC_ACQUIRE;
            lock_cnt_nxt = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= AGC_ACQUIRE;
      lock_cnt <= '0;
      gain     <= GAIN_W'(GAIN_INIT);
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      gain     <= gain_nxt;
    end
  end

  assign gain_out = gain;
  assign locked   = (state == AGC_TRACK);

endmodule

// File: tb/tb_rx_agc.sv
// Randomized bench for rx_agc against a window-list reference model of the AGC loop.
module tb_rx_agc;

  localparam int TARGET = 32768, GAIN_INIT = 16384, GAIN_MIN = 1024, GAIN_MAX = 262143;
  localparam int MU_ACQ = 2, MU_TRK = 6, LOCK_TOL = 2048, UNLOCK_TOL = 8192, LOCK_CNT = 3;
  localparam int WIN = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sam_clk_ena = 1'b0;
  logic               sym_clk_ena = 1'b0;
  logic               agc_hold = 1'b0;
  logic signed [17:0] sig_in = '0;
  logic signed [17:0] sig_out;
  logic        [17:0] gain_out;
  logic               locked;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  // Reference model state
  longint m_sig, m_gain, m_avg;
  bit     m_locked;
  int     m_lock_cnt;
  longint win_q[$];
  bit     lone_ok = 1'b0;

  rx_agc dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .agc_hold    (agc_hold),
    .sig_in      (sig_in),
    .sig_out     (sig_out),
    .gain_out    (gain_out),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_sig      = 0;
    m_gain     = GAIN_INIT;
    m_avg      = 0;
    m_locked   = 1'b0;
    m_lock_cnt = 0;
    win_q.delete();
  endtask

  task automatic model_step(input bit sam, input bit sym, input bit hold, input longint din);
    longint mag, sum, err, abs_err, g_mult, p;
    mag    = (m_sig < 0) ? -m_sig : m_sig;
    if (mag > 131071) mag = 131071;
    g_mult = m_gain;
    if (hold) begin
      win_q.delete();
    end else if (sym) begin
      win_q.push_back(mag);
      if (win_q.size() == WIN) begin
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        m_avg   = sum / WIN;
        err     = TARGET - m_avg;
        abs_err = (err < 0) ? -err : err;
        m_gain  = m_gain + (err >>> (m_locked ? MU_TRK : MU_ACQ));
        if (m_gain < GAIN_MIN) m_gain = GAIN_MIN;
        if (m_gain > GAIN_MAX) m_gain = GAIN_MAX;
        if (!m_locked) begin
          if (abs_err <= LOCK_TOL) begin
            m_lock_cnt++;
            if (m_lock_cnt == LOCK_CNT) begin
              m_locked   = 1'b1;
              m_lock_cnt = 0;
            end
          end else begin
            m_lock_cnt = 0;
          end
        end else if (abs_err > UNLOCK_TOL) begin
          m_locked   = 1'b0;
          m_lock_cnt = 0;
        end
        win_q.delete();
      end
    end
    if (sam) begin
      p = (din * g_mult) >>> 14;
      if (p > 131071) p = 131071;
      if (p < -131072) p = -131072;
      m_sig = p;
    end
    exp_q.push_back({18'(m_sig), 18'(m_gain), m_locked});
  endtask

  // Driver: one clock with the given strobes, scoreboarded right after the edge.
  task automatic tick(input bit sam, input bit sym, input bit hold, input logic signed [17:0] din);
    logic [36:0] e;
    @(negedge clk);
    sam_clk_ena = sam;
    sym_clk_ena = sym;
    agc_hold    = hold;
    sig_in      = din;
    model_step(sam, sym, hold, longint'(din));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sig_out", sig_out, $signed(e[36:19]));
    check("gain_out", gain_out, e[18:1]);
    check("locked", locked, e[0]);
  endtask

  task automatic symbol(input int base, input int noise, input bit hold);
    int val;
    logic signed [17:0] d;
    for (int k = 0; k < 4; k++) begin
      val = base;
      if (noise > 0) val = base + int'($urandom_range(2 * noise)) - noise;
      if (val > 131071) val = 131071;
      if (val < -131072) val = -131072;
      d = 18'(val);
      if ($urandom_range(3) == 0) tick(1'b0, 1'b0, hold, d);
      if (k < 3) begin
        tick(1'b1, 1'b0, hold, d);
      end else if (lone_ok && $urandom_range(7) == 0) begin
        tick(1'b1, 1'b0, hold, d);
        tick(1'b0, 1'b1, hold, d);
      end else begin
        tick(1'b1, 1'b1, hold, d);
      end
    end
  endtask

  task automatic window(input int base, input int noise);
    for (int s = 0; s < WIN; s++) symbol(base, noise, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    agc_hold    = 1'b0;
    sig_in      = '0;
    #1;
    check("rst_sig_out", sig_out, 0);
    check("rst_gain_out", gain_out, GAIN_INIT);
    check("rst_locked", locked, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_lock(input int base);
    for (int w = 0; w < 40 && !locked; w++) window(base, 32);
    check("lock_reached", locked, 1);
  endtask

  initial begin
    longint g_prev, h_gain;
    bit     h_locked;

    // Reset and the zero-input ramp
    do_reset();
    for (int w = 0; w < 3; w++) begin
      window(0, 0);
      check("ramp_gain", gain_out, GAIN_INIT + 8192 * (w + 1));
    end

    // Constant input: first window then convergence to lock
    do_reset();
    window(16384, 0);
    check("first_win_gain", gain_out, 20480);
    lone_ok = 1'b1;
    wait_lock(16384);
    check("conv_gain", (gain_out >= 30720) && (gain_out <= 34816), 1);
    check("conv_sig", (sig_out >= 30208) && (sig_out <= 35328), 1);

    // Unlock on a level step, then fast acquire step
    lone_ok = 1'b0;
    window(4096, 0);
    check("unlock", locked, 0);
    g_prev = gain_out;
    window(4096, 0);
    check("acq_step", longint'(gain_out) - g_prev, (TARGET - m_avg) >>> MU_ACQ);

    // Upper clamp, saturation and lower clamp
    do_reset();
    for (int w = 0; w < 31; w++) window(0, 0);
    check("clamp_hi", gain_out, GAIN_MAX);
    tick(1'b1, 1'b0, 1'b0, -18'sd131072);
    check("sat_out", sig_out, -131072);
    window(-131072, 0);
    check("sat_gain", gain_out, 237567);
    for (int w = 0; w < 16; w++) begin
      window(-131072, 0);
      check("gain_floor", gain_out >= GAIN_MIN, 1);
    end

    // Hold mid-window for three windows with varying input
    lone_ok = 1'b1;
    wait_lock(16384);
    lone_ok = 1'b0;
    for (int s = 0; s < 7; s++) symbol(16384, 32, 1'b0);
    h_gain   = m_gain;
    h_locked = m_locked;
    for (int s = 0; s < 3 * WIN; s++) begin
      symbol(int'($urandom_range(100000)) - 50000, 2000, 1'b1);
      check("hold_gain", gain_out, h_gain);
      check("hold_locked", locked, h_locked);
    end
    for (int s = 0; s < WIN - 1; s++) begin
      symbol(8192, 0, 1'b0);
      check("post_hold_gain", gain_out, h_gain);
    end
    symbol(8192, 0, 1'b0);
    check("post_hold_unlock", locked, 0);
    check("post_hold_update", gain_out, h_gain + ((TARGET - m_avg) >>> MU_TRK));

    // Asynchronous reset mid-window after lock, window restarts
    lone_ok = 1'b1;
    wait_lock(16384);
    lone_ok = 1'b0;
    for (int s = 0; s < 5; s++) symbol(16384, 32, 1'b0);
    do_reset();
    for (int s = 0; s < WIN - 1; s++) symbol(16384, 0, 1'b0);
    check("restart_pending", gain_out, GAIN_INIT);
    symbol(16384, 0, 1'b0);
    check("restart_gain", gain_out, 20480);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
